// File: rtl/mem_stage_p.sv
// rtl/mem_stage_p.sv - EX/MEM pipeline register, data RAM and memory-mapped timer/LED/switch/7-seg block.
module mem_stage_p #(
  parameter int RAM_WORDS = 256,
  parameter int RAM_AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Flush_mem,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemWriteData,
  input  logic [4:0]  RegWriteAddr,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemToReg_ex,
  input  logic [31:0] PC_4_ex,
  input  logic [7:0]  switch,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_mem,
  output logic [1:0]  MemToReg_mem,
  output logic [31:0] PC_4_mem,
  output logic [31:0] MemReadData_mem,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [4:0]  reg_write_addr_q, reg_write_addr_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  mem_to_reg_q, mem_to_reg_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;

  logic [31:0] ram_q [RAM_WORDS];

  logic              ram_sel;
  logic              periph_sel;
  logic [2:0]        periph_reg;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic [31:0]       rdata;

  always_comb begin
    ram_sel    = (alu_result_q[31:RAM_AW+2] == '0);
    ram_idx    = alu_result_q[RAM_AW+1:2];
    periph_sel = (alu_result_q[31:5] == PERIPH_BASE[31:5]);
    periph_reg = alu_result_q[4:2];
    ram_we     = mem_write_q && ram_sel && !reset;

    rdata = '0;
    if (ram_sel) begin
      rdata = ram_q[ram_idx];
    end else if (periph_sel) begin
      case (periph_reg)
        3'd0:    rdata = th_q;
        3'd1:    rdata = tl_q;
        3'd2:    rdata = {29'd0, tcon_q};
        3'd3:    rdata = {24'd0, led_q};
        3'd4:    rdata = {24'd0, switch};
        3'd5:    rdata = {20'd0, digi_q};
        default: rdata = '0;
      endcase
    end
  end

  // Timer update first; a software store in the same cycle then overrides its target register.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    if (tcon_q[0]) begin
      if (tl_q != 32'hFFFF_FFFF) begin
        tl_d = tl_q + 32'd1;
      end else begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end
    end
    if (mem_write_q && periph_sel) begin
      case (periph_reg)
        3'd0:    th_d   = mem_write_data_q;
        3'd1:    tl_d   = mem_write_data_q;
        3'd2:    tcon_d = mem_write_data_q[2:0];
        3'd3:    led_d  = mem_write_data_q[7:0];
        3'd5:    digi_d = mem_write_data_q[11:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_result_d     = ALUResult;
    mem_write_data_d = MemWriteData;
    reg_write_addr_d = RegWriteAddr;
    reg_write_d      = RegWrite_ex;
    mem_read_d       = MemRead_ex;
    mem_write_d      = MemWrite_ex;
    mem_to_reg_d     = MemToReg_ex;
    pc_4_d           = PC_4_ex;
    if (Flush_mem) begin
      alu_result_d     = '0;
      mem_write_data_d = '0;
      reg_write_addr_d = '0;
      reg_write_d      = 1'b0;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      mem_to_reg_d     = '0;
      pc_4_d           = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q     <= '0;
      mem_write_data_q <= '0;
      reg_write_addr_q <= '0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_to_reg_q     <= '0;
      pc_4_q           <= '0;
      th_q             <= '0;
      tl_q             <= '0;
      tcon_q           <= '0;
      led_q            <= '0;
      digi_q           <= '0;
    end else begin
      alu_result_q     <= alu_result_d;
      mem_write_data_q <= mem_write_data_d;
      reg_write_addr_q <= reg_write_addr_d;
      reg_write_q      <= reg_write_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      pc_4_q           <= pc_4_d;
      th_q             <= th_d;
      tl_q             <= tl_d;
      tcon_q           <= tcon_d;
      led_q            <= led_d;
      digi_q           <= digi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_write_data_q;
  end

  assign ALUResult_mem    = alu_result_q;
  assign RegWriteAddr_mem = reg_write_addr_q;
  assign RegWrite_mem     = reg_write_q;
  assign MemToReg_mem     = mem_to_reg_q;
  assign PC_4_mem         = pc_4_q;
  assign MemReadData_mem  = mem_read_q ? rdata : '0;
  assign led              = led_q;
  assign digi             = digi_q;
  assign irq              = tcon_q[1] & tcon_q[2];
endmodule
